// File: rtl/se_channel_scheduler_pkg.sv
// Shared types and channel-count helpers for the folded spatial encoder scheduler.
package se_sched_pkg;

    typedef enum logic [1:0] {
        MOD_GSR = 2'b00,
        MOD_ECG = 2'b01,
        MOD_EEG = 2'b10
    } modality_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GSR,
        ST_ECG,
        ST_EEG
    } sched_state_e;

    localparam int GSR_CHANNELS_DEFAULT = 32;
    localparam int ECG_CHANNELS_DEFAULT = 77;
    localparam int EEG_CHANNELS_DEFAULT = 105;

    // Channel count of a modality for a given configuration; the unused 2'b11
    // encoding falls back to EEG so lookup tables stay fully populated.
    function automatic int channels_of(
        input modality_e m,
        input int        gsr_n,
        input int        ecg_n,
        input int        eeg_n
    );
        case (m)
            MOD_GSR: return gsr_n;
            MOD_ECG: return ecg_n;
            default: return eeg_n;
        endcase
    endfunction

endpackage

// File: rtl/se_channel_scheduler_wrap_counter.sv
// Up-counter that wraps to zero after reaching a run-time selectable limit.
module wrap_counter #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    assign at_max = (count_reg == limit);
    assign count  = count_reg;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (inc) begin
            count_next = at_max ? '0 : count_reg + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/se_channel_scheduler.sv
// Walks fold -> modality -> channel for each accepted sample, one fetch beat per
// channel plus a flush beat closing every modality pass.
module se_channel_scheduler
    import se_sched_pkg::*;
#(
    parameter int NUM_FOLDS       = 1,
    parameter int NUM_FOLDS_WIDTH = 1,
    parameter int GSR_NUM_CHANNEL = GSR_CHANNELS_DEFAULT,
    parameter int ECG_NUM_CHANNEL = ECG_CHANNELS_DEFAULT,
    parameter int EEG_NUM_CHANNEL = EEG_CHANNELS_DEFAULT,
    parameter int CHANNEL_WIDTH   = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_valid,
    output logic                       start_ready,
    output logic                       fetch_valid,
    input  logic                       fetch_ready,
    output logic [1:0]                 fetch_modality,
    output logic [CHANNEL_WIDTH-1:0]   fetch_channel,
    output logic [NUM_FOLDS_WIDTH-1:0] fetch_fold,
    output logic                       fetch_flush,
    output logic                       fetch_last,
    output logic                       busy,
    output logic                       done
);

    localparam logic [NUM_FOLDS_WIDTH-1:0] FOLD_MAX = NUM_FOLDS_WIDTH'(NUM_FOLDS - 1);

    sched_state_e state_reg, state_next;
    logic         flush_reg, flush_next;
    logic         done_reg, done_next;

    modality_e                  cur_mod;
    logic                       active;
    logic                       start_fire;
    logic                       fire;
    logic [CHANNEL_WIDTH-1:0]   ch_count;
    logic [CHANNEL_WIDTH-1:0]   ch_limit;
    logic                       ch_at_max;
    logic [NUM_FOLDS_WIDTH-1:0] fold_count;
    logic                       fold_at_max;
    logic [CHANNEL_WIDTH-1:0]   limit_table [4];

    // Last-channel index per modality encoding, indexed directly by cur_mod.
    for (genvar gi = 0; gi < 4; gi++) begin : g_limit
        assign limit_table[gi] = CHANNEL_WIDTH'(channels_of(modality_e'(2'(gi)),
                                                            GSR_NUM_CHANNEL,
                                                            ECG_NUM_CHANNEL,
                                                            EEG_NUM_CHANNEL) - 1);
    end

    always_comb begin
        cur_mod = MOD_GSR;
        case (state_reg)
            ST_ECG:  cur_mod = MOD_ECG;
            ST_EEG:  cur_mod = MOD_EEG;
            default: cur_mod = MOD_GSR;
        endcase
    end

    assign active     = (state_reg != ST_IDLE);
    assign start_fire = start_valid && !active;
    assign fire       = active && fetch_ready;
    assign ch_limit   = limit_table[cur_mod];

    // Channel index stays at zero during the flush beat, so it only advances
    // on non-flush fires and wraps naturally into the flush slot.
    wrap_counter #(
        .WIDTH (CHANNEL_WIDTH)
    ) u_channel_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (start_fire),
        .inc    (fire && !flush_reg),
        .limit  (ch_limit),
        .count  (ch_count),
        .at_max (ch_at_max)
    );

    wrap_counter #(
        .WIDTH (NUM_FOLDS_WIDTH)
    ) u_fold_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (start_fire),
        .inc    (fire && flush_reg && (state_reg == ST_EEG)),
        .limit  (FOLD_MAX),
        .count  (fold_count),
        .at_max (fold_at_max)
    );

    always_comb begin
        state_next = state_reg;
        flush_next = flush_reg;
        done_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_valid) begin
                    state_next = ST_GSR;
                    flush_next = 1'b0;
                end
            end
            default: begin
                if (fetch_ready) begin
                    if (flush_reg) begin
                        flush_next = 1'b0;
                        case (state_reg)
                            ST_GSR:  state_next = ST_ECG;
                            ST_ECG:  state_next = ST_EEG;
                            default: begin
                                state_next = fold_at_max ? ST_IDLE : ST_GSR;
                                done_next  = fold_at_max;
                            end
                        endcase
                    end else if (ch_at_max) begin
                        flush_next = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            flush_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            flush_reg <= flush_next;
            done_reg  <= done_next;
        end
    end

    assign start_ready    = !active;
    assign fetch_valid    = active;
    assign busy           = active;
    assign fetch_modality = cur_mod;
    assign fetch_channel  = ch_count;
    assign fetch_fold     = fold_count;
    assign fetch_flush    = flush_reg;
    assign fetch_last     = active && flush_reg && (state_reg == ST_EEG) && fold_at_max;
    assign done           = done_reg;

endmodule

// File: tb/tb_se_channel_scheduler.sv
// Directed bench for se_channel_scheduler: default and folded/GSR=1 instances.
module tb_se_channel_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst [2];
    logic start_valid [2];
    logic fetch_ready [2];
    int   sel;

    logic       a_start_ready, a_valid, a_flush, a_last, a_busy, a_done;
    logic [1:0] a_mod;
    logic [6:0] a_ch;
    logic [0:0] a_fold;
    logic       b_start_ready, b_valid, b_flush, b_last, b_busy, b_done;
    logic [1:0] b_mod;
    logic [6:0] b_ch;
    logic [1:0] b_fold;

    se_channel_scheduler dut_a (
        .clk            (clk),
        .rst            (rst[0]),
        .start_valid    (start_valid[0]),
        .start_ready    (a_start_ready),
        .fetch_valid    (a_valid),
        .fetch_ready    (fetch_ready[0]),
        .fetch_modality (a_mod),
        .fetch_channel  (a_ch),
        .fetch_fold     (a_fold),
        .fetch_flush    (a_flush),
        .fetch_last     (a_last),
        .busy           (a_busy),
        .done           (a_done)
    );

    se_channel_scheduler #(
        .NUM_FOLDS       (4),
        .NUM_FOLDS_WIDTH (2),
        .GSR_NUM_CHANNEL (1)
    ) dut_b (
        .clk            (clk),
        .rst            (rst[1]),
        .start_valid    (start_valid[1]),
        .start_ready    (b_start_ready),
        .fetch_valid    (b_valid),
        .fetch_ready    (fetch_ready[1]),
        .fetch_modality (b_mod),
        .fetch_channel  (b_ch),
        .fetch_fold     (b_fold),
        .fetch_flush    (b_flush),
        .fetch_last     (b_last),
        .busy           (b_busy),
        .done           (b_done)
    );

    logic        obs_start_ready, obs_valid, obs_flush, obs_last, obs_busy, obs_done;
    logic [1:0]  obs_mod, obs_fold;
    logic [6:0]  obs_ch;
    logic [12:0] obs_pack;

    assign obs_start_ready = (sel == 1) ? b_start_ready : a_start_ready;
    assign obs_valid       = (sel == 1) ? b_valid : a_valid;
    assign obs_flush       = (sel == 1) ? b_flush : a_flush;
    assign obs_last        = (sel == 1) ? b_last : a_last;
    assign obs_busy        = (sel == 1) ? b_busy : a_busy;
    assign obs_done        = (sel == 1) ? b_done : a_done;
    assign obs_mod         = (sel == 1) ? b_mod : a_mod;
    assign obs_ch          = (sel == 1) ? b_ch : a_ch;
    assign obs_fold        = (sel == 1) ? b_fold : {1'b0, a_fold};
    assign obs_pack        = {obs_last, obs_flush, obs_fold, obs_mod, obs_ch};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected {last, flush, fold, modality, channel} of beat idx within a sample.
    function automatic logic [12:0] exp_beat(input int idx, input int gsr_n, input int folds);
        int         per, f, r;
        logic [1:0] m;
        logic [6:0] ch;
        logic       fl, la;
        per = gsr_n + 77 + 105 + 3;
        f   = idx / per;
        r   = idx % per;
        ch  = '0;
        fl  = 1'b0;
        la  = 1'b0;
        if (r < gsr_n + 1) begin
            m = 2'd0;
            if (r == gsr_n) fl = 1'b1; else ch = 7'(r);
        end else begin
            r = r - (gsr_n + 1);
            if (r < 78) begin
                m = 2'd1;
                if (r == 77) fl = 1'b1; else ch = 7'(r);
            end else begin
                r = r - 78;
                m = 2'd2;
                if (r == 105) begin
                    fl = 1'b1;
                    la = (f == folds - 1);
                end else begin
                    ch = 7'(r);
                end
            end
        end
        return {la, fl, 2'(f), m, ch};
    endfunction

    task automatic run_sample(input int s, input int nbeats, input int gsr_n, input int folds,
                              input bit rnd, input bit do_start, input bit hold_start);
        int          beat, cyc, lasts, rdy_busy;
        bit          stall;
        logic [13:0] prev;
        logic        rdy;
        beat = 0; cyc = 0; lasts = 0; rdy_busy = 0; stall = 1'b0; prev = '0;
        sel = s;
        if (do_start) begin
            check("start_ready_idle", 32'(obs_start_ready), 32'd1);
            start_valid[s] = 1'b1;
            @(negedge clk);
            check("first_beat_latency", 32'(obs_valid), 32'd1);
        end
        if (!hold_start) start_valid[s] = 1'b0;
        while (beat < nbeats && cyc < nbeats * 4 + 50) begin
            if (stall) check("hold_stable", 32'({obs_valid, obs_pack}), 32'(prev));
            if (obs_busy && obs_start_ready) rdy_busy++;
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            fetch_ready[s] = rdy;
            if (obs_valid && rdy) begin
                check($sformatf("beat%0d", beat), 32'(obs_pack), 32'(exp_beat(beat, gsr_n, folds)));
                if (obs_last) lasts++;
                beat++;
            end
            stall = obs_valid && !rdy;
            prev  = {obs_valid, obs_pack};
            cyc++;
            @(negedge clk);
        end
        fetch_ready[s] = 1'b0;
        check("beat_count", 32'(beat), 32'(nbeats));
        if (!rnd) check("cycle_count", 32'(cyc), 32'(nbeats));
        check("last_count", 32'(lasts), 32'd1);
        check("rdy_while_busy", 32'(rdy_busy), 32'd0);
        check("done_pulse", 32'(obs_done), 32'd1);
        check("idle_after", 32'(obs_busy), 32'd0);
    endtask

    initial begin
        logic d;
        rst         = '{1'b1, 1'b1};
        start_valid = '{1'b0, 1'b0};
        fetch_ready = '{1'b0, 1'b0};
        sel         = 0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            check("rst_start_ready", 32'(obs_start_ready), 32'd1);
            check("rst_valid", 32'(obs_valid), 32'd0);
            check("rst_busy", 32'(obs_busy), 32'd0);
            check("rst_done", 32'(obs_done), 32'd0);
            check("rst_fields", 32'(obs_pack), 32'd0);
        end
        rst = '{1'b0, 1'b0};
        @(negedge clk);

        $display("sample: default, full rate");
        run_sample(0, 217, 32, 1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("done_one_cycle", 32'(obs_done), 32'd0);

        $display("sample: default, random ready");
        run_sample(0, 217, 32, 1, 1'b1, 1'b1, 1'b0);

        $display("sample: 4 folds, GSR=1");
        run_sample(1, 744, 1, 4, 1'b0, 1'b1, 1'b0);

        $display("sample: back-to-back with start held");
        run_sample(0, 217, 32, 1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("b2b_first_valid", 32'(obs_valid), 32'd1);
        check("b2b_first_beat", 32'(obs_pack), 32'(exp_beat(0, 32, 1)));
        run_sample(0, 217, 32, 1, 1'b0, 1'b0, 1'b0);

        $display("sample: reset at ECG channel 40");
        sel = 0;
        @(negedge clk);
        start_valid[0] = 1'b1;
        fetch_ready[0] = 1'b1;
        @(negedge clk);
        start_valid[0] = 1'b0;
        repeat (73) @(negedge clk);
        check("mid_modality", 32'(obs_mod), 32'd1);
        check("mid_channel", 32'(obs_ch), 32'd40);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        check("abort_valid", 32'(obs_valid), 32'd0);
        check("abort_busy", 32'(obs_busy), 32'd0);
        check("abort_start_ready", 32'(obs_start_ready), 32'd1);
        check("abort_fields", 32'(obs_pack), 32'd0);
        d = obs_done;
        repeat (3) begin
            @(negedge clk);
            d = d | obs_done;
        end
        check("abort_no_done", 32'(d), 32'd0);
        fetch_ready[0] = 1'b0;

        $display("sample: restart after abort");
        run_sample(0, 217, 32, 1, 1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
